// File: rtl/conv_weight_pkg.sv
// Shared definitions for the conv weight loader and the conv address decode.
package conv_weight_pkg;

  localparam int unsigned WORD_W  = 32;
  localparam int unsigned COEFF_W = 16;

  // Load sequence: kernels, biases, MACC coefficient, layer scale.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_KERNEL,
    ST_BIAS,
    ST_COEFF,
    ST_SCALE,
    ST_DONE
  } wl_state_t;

  // Number of kernel weight words for one layer.
  function automatic int unsigned kernel_words(input int unsigned k0,
                                               input int unsigned k1,
                                               input int unsigned ic,
                                               input int unsigned oc);
    return k0 * k1 * ic * oc;
  endfunction

endpackage

// File: rtl/conv_weight_loader.sv
// Streams 32-bit weight words into the conv weight write port, walking the
// layer address map: kernels, biases, MACC coefficient, layer scale.
module conv_weight_loader
  import conv_weight_pkg::*;
#(
  parameter int unsigned KERNEL_0              = 3,
  parameter int unsigned KERNEL_1              = 3,
  parameter int unsigned IN_CHANNEL            = 2,
  parameter int unsigned OUT_CHANNEL           = 2,
  parameter int unsigned KERNEL_BASE_ADDR      = 0,
  parameter int unsigned BIAS_BASE_ADDR        = KERNEL_BASE_ADDR +
                           kernel_words(KERNEL_0, KERNEL_1, IN_CHANNEL, OUT_CHANNEL),
  parameter int unsigned MACC_COEFF_BASE_ADDR  = BIAS_BASE_ADDR + OUT_CHANNEL,
  parameter int unsigned LAYER_SCALE_BASE_ADDR = MACC_COEFF_BASE_ADDR + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [WORD_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic [WORD_W-1:0] weight_wr_data,
  output logic [WORD_W-1:0] weight_wr_addr,
  output logic              weight_wr_en,
  output logic              busy,
  output logic              done
);

  localparam int unsigned KW      = kernel_words(KERNEL_0, KERNEL_1, IN_CHANNEL, OUT_CHANNEL);
  localparam int unsigned MAX_CNT = (KW > OUT_CHANNEL) ? KW : OUT_CHANNEL;
  localparam int unsigned IDX_W   = $clog2(MAX_CNT) + 1;

  localparam logic [IDX_W-1:0]  KERNEL_LAST = IDX_W'(KW - 1);
  localparam logic [IDX_W-1:0]  BIAS_LAST   = IDX_W'(OUT_CHANNEL - 1);
  localparam logic [WORD_W-1:0] KERNEL_BASE = WORD_W'(KERNEL_BASE_ADDR);
  localparam logic [WORD_W-1:0] BIAS_BASE   = WORD_W'(BIAS_BASE_ADDR);
  localparam logic [WORD_W-1:0] COEFF_ADDR  = WORD_W'(MACC_COEFF_BASE_ADDR);
  localparam logic [WORD_W-1:0] SCALE_ADDR  = WORD_W'(LAYER_SCALE_BASE_ADDR);

  wl_state_t         state, state_next;
  logic [IDX_W-1:0]  idx, idx_next;
  logic              wr_en_next;
  logic [WORD_W-1:0] wr_addr_next, wr_data_next;
  logic [WORD_W-1:0] coeff_data;
  logic              hs;

  assign s_ready    = (state == ST_KERNEL) || (state == ST_BIAS) ||
                      (state == ST_COEFF)  || (state == ST_SCALE);
  assign busy       = (state != ST_IDLE);
  assign done       = (state == ST_DONE);
  assign hs         = s_valid && s_ready;
  assign coeff_data = {{(WORD_W - COEFF_W){1'b0}}, s_data[COEFF_W-1:0]};

  // Next-state, index and write-port decode; abort overrides any handshake.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path can leave
    // one unassigned and infer a latch.
    state_next   = state;
    idx_next     = idx;
    wr_en_next   = 1'b0;
    wr_addr_next = weight_wr_addr;
    wr_data_next = weight_wr_data;

    case (state)
      ST_IDLE: begin
        if (start) begin
          state_next = ST_KERNEL;
          idx_next   = '0;
        end
      end
      ST_KERNEL: begin
        if (hs) begin
          wr_en_next   = 1'b1;
          wr_addr_next = KERNEL_BASE + WORD_W'(idx);
          wr_data_next = s_data;
          if (idx == KERNEL_LAST) begin
            idx_next   = '0;
            state_next = ST_BIAS;
          end else begin
            idx_next = idx + 1'b1;
          end
        end
      end
      ST_BIAS: begin
        if (hs) begin
          wr_en_next   = 1'b1;
          wr_addr_next = BIAS_BASE + WORD_W'(idx);
          wr_data_next = s_data;
          if (idx == BIAS_LAST) begin
            idx_next   = '0;
            state_next = ST_COEFF;
          end else begin
            idx_next = idx + 1'b1;
          end
        end
      end
      ST_COEFF: begin
        if (hs) begin
          wr_en_next   = 1'b1;
          wr_addr_next = COEFF_ADDR;
          wr_data_next = coeff_data;
          state_next   = ST_SCALE;
        end
      end
      ST_SCALE: begin
        if (hs) begin
          wr_en_next   = 1'b1;
          wr_addr_next = SCALE_ADDR;
          wr_data_next = coeff_data;
          state_next   = ST_DONE;
        end
      end
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase

    // The word presented alongside abort is dropped; addr/data keep their value.
    if (abort) begin
      state_next   = ST_IDLE;
      wr_en_next   = 1'b0;
      wr_addr_next = weight_wr_addr;
      wr_data_next = weight_wr_data;
    end
  end

  // State, index and registered write port.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (!rst_n) begin
      state          <= ST_IDLE;
      idx            <= '0;
      weight_wr_en   <= 1'b0;
      weight_wr_addr <= '0;
      weight_wr_data <= '0;
    end else begin
      state          <= state_next;
      idx            <= idx_next;
      weight_wr_en   <= wr_en_next;
      weight_wr_addr <= wr_addr_next;
      weight_wr_data <= wr_data_next;
    end
  end

endmodule

// File: tb/tb_conv_weight_loader.sv
// Self-checking bench for conv_weight_loader with default parameters.
module tb_conv_weight_loader;
  import conv_weight_pkg::*;

  localparam int NW         = 40;  // 36 kernel + 2 bias + coeff + scale
  localparam int COEFF_POS  = 38;
  localparam int SCALE_POS  = 39;
  localparam int BUDGET     = 2000;

  logic        clk, rst_n, start, abort, s_valid, s_ready;
  logic [31:0] s_data, weight_wr_data, weight_wr_addr;
  logic        weight_wr_en, busy, done;

  conv_weight_loader dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .abort          (abort),
    .s_data         (s_data),
    .s_valid        (s_valid),
    .s_ready        (s_ready),
    .weight_wr_data (weight_wr_data),
    .weight_wr_addr (weight_wr_addr),
    .weight_wr_en   (weight_wr_en),
    .busy           (busy),
    .done           (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [31:0] words [NW];
  logic [31:0] log_addr [$];
  logic [31:0] log_data [$];
  int          log_cyc  [$];
  int          hs_cyc   [$];
  int          done_cnt;
  logic        done_last;

  always @(posedge clk) cyc <= cyc + 1;

  // Record every write and every done pulse, sampled mid-cycle.
  always @(negedge clk) begin
    if (weight_wr_en) begin
      log_addr.push_back(weight_wr_addr);
      log_data.push_back(weight_wr_data);
      log_cyc.push_back(cyc);
    end
    if (done) begin
      done_cnt++;
      done_last = weight_wr_en && (weight_wr_addr == 32'(SCALE_POS)) && busy;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: stream position k lands at address k; coeff and scale keep low 16 bits.
  function automatic logic [31:0] exp_data(input int k, input logic [31:0] w);
    if (k == COEFF_POS || k == SCALE_POS) return {16'h0, w[15:0]};
    return w;
  endfunction

  task automatic fill_random();
    for (int i = 0; i < NW; i++) words[i] = $urandom;
  endtask

  // Clear logs, check idle, pulse start, check the loader opened.
  task automatic begin_load();
    @(negedge clk);
    #1;
    log_addr.delete(); log_data.delete(); log_cyc.delete(); hs_cyc.delete();
    done_cnt  = 0;
    done_last = 1'b0;
    check("idle_ready", s_ready, 1'b0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("start_ready", s_ready, 1'b1);
    check("start_busy", busy, 1'b1);
  endtask

  // mode 0: valid high, 1: toggle, 2: random. abort_at/start_at < 0 disables.
  task automatic stream(input int n, input int mode, input int abort_at, input int start_at);
    int  sent = 0;
    int  t    = 0;
    bit  stop = 0;
    while (sent < n && t < BUDGET && !stop) begin
      @(negedge clk);
      case (mode)
        0:       s_valid = 1'b1;
        1:       s_valid = (t % 2 == 0);
        default: s_valid = 1'($urandom_range(0, 1));
      endcase
      s_data = words[sent];
      abort  = (abort_at >= 0 && sent == abort_at);
      start  = (t == start_at);
      if (abort) stop = 1;
      else if (s_valid && s_ready) begin
        hs_cyc.push_back(cyc + 1);
        sent++;
      end
      t++;
    end
    @(negedge clk);
    s_valid = 1'b0;
    abort   = 1'b0;
    start   = 1'b0;
    check("stream_budget", 32'(t < BUDGET), 32'd1);
  endtask

  task automatic wait_idle();
    int t = 0;
    while (busy && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("idle_timeout", 32'(t < 50), 32'd1);
    @(negedge clk);
    #1;
  endtask

  task automatic verify(input string tag, input int nexp, input int exp_done);
    int n;
    check({tag, "_count"}, 32'(log_addr.size()), 32'(nexp));
    n = (log_addr.size() < nexp) ? log_addr.size() : nexp;
    for (int i = 0; i < n; i++) begin
      check({tag, "_addr"}, log_addr[i], 32'(i));
      check({tag, "_data"}, log_data[i], exp_data(i, words[i]));
      if (i < hs_cyc.size()) check({tag, "_latency"}, 32'(log_cyc[i]), 32'(hs_cyc[i]));
    end
    check({tag, "_done_cnt"}, 32'(done_cnt), 32'(exp_done));
    if (exp_done != 0) check({tag, "_done_last"}, done_last, 1'b1);
  endtask

  initial begin
    rst_n   = 1'b0;
    start   = 1'b0;
    abort   = 1'b0;
    s_valid = 1'b0;
    s_data  = '0;
    done_cnt  = 0;
    done_last = 1'b0;
    #1;
    check("rst_ready", s_ready, 1'b0);
    check("rst_en", weight_wr_en, 1'b0);
    check("rst_addr", weight_wr_addr, 32'h0);
    check("rst_data", weight_wr_data, 32'h0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    #20;
    rst_n = 1'b1;

    // Contiguous 0..39 with valid held high.
    for (int i = 0; i < NW; i++) words[i] = 32'(i);
    begin_load();
    stream(NW, 0, -1, -1);
    wait_idle();
    verify("seq", NW, 1);
    check("hold_en", weight_wr_en, 1'b0);
    check("hold_addr", weight_wr_addr, 32'd39);
    check("hold_data", weight_wr_data, 32'd39);
    check("idle_busy", busy, 1'b0);

    // Coefficient and scale truncation to 16 bits.
    fill_random();
    words[COEFF_POS] = 32'hDEAD8000;
    words[SCALE_POS] = 32'h12340800;
    begin_load();
    stream(NW, 0, -1, -1);
    wait_idle();
    verify("coeff", NW, 1);
    if (log_data.size() == NW) begin
      check("coeff_word", log_data[COEFF_POS], 32'h00008000);
      check("scale_word", log_data[SCALE_POS], 32'h00000800);
    end else begin
      check("coeff_size", 32'(log_data.size()), 32'(NW));
    end

    // Bubbles every other cycle.
    fill_random();
    begin_load();
    stream(NW, 1, -1, -1);
    wait_idle();
    verify("toggle", NW, 1);

    // Abort together with the 11th valid word.
    fill_random();
    begin_load();
    stream(NW, 0, 10, -1);
    check("abort_busy", busy, 1'b0);
    check("abort_ready", s_ready, 1'b0);
    repeat (3) @(negedge clk);
    #1;
    verify("abort", 10, 0);

    // Restart after abort, random bubbles.
    fill_random();
    begin_load();
    stream(NW, 2, -1, -1);
    wait_idle();
    verify("restart", NW, 1);

    // Reset in the middle of the bias section.
    fill_random();
    begin_load();
    stream(37, 0, -1, -1);
    check("bias_busy", busy, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_en", weight_wr_en, 1'b0);
    check("mid_rst_addr", weight_wr_addr, 32'h0);
    check("mid_rst_data", weight_wr_data, 32'h0);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_ready", s_ready, 1'b0);
    check("mid_rst_done", done, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("post_rst_busy", busy, 1'b0);
    fill_random();
    begin_load();
    stream(NW, 0, -1, -1);
    wait_idle();
    verify("after_rst", NW, 1);

    // Start pulsed during the kernel section must be ignored.
    fill_random();
    begin_load();
    stream(NW, 0, -1, 15);
    wait_idle();
    verify("start_glitch", NW, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
